// File: rtl/mult_c3x2_rr_scheduler.sv
// Two-requester round-robin front end for one external C3x2 multiplier: S1 issues operands, S2 merges and returns results.
// Optional MULT_SCHED_MODE_CHECK_EN: mode 11 completes as an error result instead of running as 18x12.
module mult_c3x2_rr_scheduler #(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [35:0]       req0_a,
  input  logic [35:0]       req0_b,
  input  logic              req0_a_sign,
  input  logic              req0_b_sign,
  input  logic [1:0]        req0_mode,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [35:0]       req1_a,
  input  logic [35:0]       req1_b,
  input  logic              req1_a_sign,
  input  logic              req1_b_sign,
  input  logic [1:0]        req1_mode,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [35:0]       mul_a,
  output logic [35:0]       mul_b,
  output logic              mul_a_sign,
  output logic              mul_b_sign,
  output logic [2:0]        mul_mode,
  input  logic [29:0]       mul_result_0,
  input  logic [29:0]       mul_result_1,
  input  logic [7:0]        mul_result_SIDM_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_src,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        out_mode,
  output logic              out_err
);

  localparam int DATA_W = 36;

  logic             vld_p1;
  logic [1:0]       mode_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             src_p1;
  logic             last;
  logic             s1_load;
  logic             s2_load;
  logic             grant0;
  logic             grant1;
  logic [32:0]      merged;

  function automatic logic [2:0] map_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? 3'b000 : {1'b0, mode};
  endfunction

  // Returns {err, data}; lane sums are rebuilt from the two partial results plus the lane carries.
  function automatic logic [32:0] merge(input logic [1:0] mode, input logic [29:0] r0,
                                        input logic [29:0] r1, input logic [7:0] c);
    logic signed [29:0] s18;
    logic signed [31:0] s18_ext;
    logic [19:0]        s6_lo;
    logic [13:0]        s6_hi;
    logic [13:0]        q0;
    logic [7:0]         q1;
    logic [7:0]         q2;
    logic [7:0]         q3;
    logic [31:0]        data;
    logic               err;
    s18     = signed'(r0 + r1);
    s18_ext = s18;
    s6_lo   = {c[3:2], r0[17:0]} + {2'b00, r1[17:0]};
    s6_hi   = {c[7:6], r0[29:18]} + {2'b00, r1[29:18]};
    q0      = {c[1:0], r0[11:0]} + {2'b00, r1[11:0]};
    q1      = {c[3:2], r0[17:12]} + {2'b00, r1[17:12]};
    q2      = {c[5:4], r0[23:18]} + {2'b00, r1[23:18]};
    q3      = {c[7:6], r0[29:24]} + {2'b00, r1[29:24]};
    err     = 1'b0;
    case (mode)
      2'b01:   data = {4'b0000, s6_hi, s6_lo[19:6]};
      2'b10:   data = {q3, q2, q1, q0[13:6]};
`ifdef MULT_SCHED_MODE_CHECK_EN
      2'b11: begin
        data = 32'd0;
        err  = 1'b1;
      end
`endif
      default: data = s18_ext;
    endcase
    return {err, data};
  endfunction

  assign s2_load = vld_p1 & (~out_valid | out_ready);
  assign s1_load = ~vld_p1 | s2_load;

  // last == 1 means req1 was granted most recently, so req0 has priority on contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (s1_load && !reset) begin
      if (req0_valid && (!req1_valid || last)) grant0 = 1'b1;
      else if (req1_valid)                     grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign merged     = merge(mode_p1, mul_result_0, mul_result_1, mul_result_SIDM_carry);

  // ---- S1: issue register driving the multiplier ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      last       <= 1'b1;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_a_sign <= 1'b0;
      mul_b_sign <= 1'b0;
      mul_mode   <= 3'b000;
    end else begin
      if (s1_load) vld_p1 <= grant0 | grant1;
      if (grant0 | grant1) last <= grant1;
      if (grant0) begin
        mul_a      <= req0_a[DATA_W-1:0];
        mul_b      <= req0_b[DATA_W-1:0];
        mul_a_sign <= req0_a_sign;
        mul_b_sign <= req0_b_sign;
        mul_mode   <= map_mode(req0_mode);
      end else if (grant1) begin
        mul_a      <= req1_a[DATA_W-1:0];
        mul_b      <= req1_b[DATA_W-1:0];
        mul_a_sign <= req1_a_sign;
        mul_b_sign <= req1_b_sign;
        mul_mode   <= map_mode(req1_mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant0) begin
      mode_p1 <= req0_mode;
      tag_p1  <= req0_tag;
      src_p1  <= 1'b0;
    end else if (grant1) begin
      mode_p1 <= req1_mode;
      tag_p1  <= req1_tag;
      src_p1  <= 1'b1;
    end
  end

  // ---- S2: merged result held under backpressure ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_src   <= 1'b0;
      out_tag   <= '0;
      out_mode  <= 2'b00;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_data  <= merged[31:0];
      out_err   <= merged[32];
      out_src   <= src_p1;
      out_tag   <= tag_p1;
      out_mode  <= mode_p1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_c3x2_rr_scheduler.sv
// Randomized bench for mult_c3x2_rr_scheduler with a stand-in multiplier and a transaction-level scoreboard.
module tb_mult_c3x2_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [35:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_a_sign = 1'b0, req0_b_sign = 1'b0, req1_a_sign = 1'b0, req1_b_sign = 1'b0;
  logic [1:0]  req0_mode = '0, req1_mode = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic [35:0] mul_a, mul_b;
  logic        mul_a_sign, mul_b_sign;
  logic [2:0]  mul_mode;
  logic [29:0] mul_result_0, mul_result_1;
  logic [7:0]  mul_result_SIDM_carry;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_src;
  logic [3:0]  out_tag;
  logic [1:0]  out_mode;
  logic        out_err;

  always #5 clk = ~clk;

  mult_c3x2_rr_scheduler #(.TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_a_sign(req0_a_sign), .req0_b_sign(req0_b_sign), .req0_mode(req0_mode), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_a_sign(req1_a_sign), .req1_b_sign(req1_b_sign), .req1_mode(req1_mode), .req1_tag(req1_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_sign(mul_a_sign), .mul_b_sign(mul_b_sign), .mul_mode(mul_mode),
    .mul_result_0(mul_result_0), .mul_result_1(mul_result_1), .mul_result_SIDM_carry(mul_result_SIDM_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .out_tag(out_tag), .out_mode(out_mode), .out_err(out_err)
  );

  typedef struct {
    logic [35:0] a;
    logic [35:0] b;
    logic        as_;
    logic        bs;
    logic [1:0]  mode;
    logic [3:0]  tag;
    logic        src;
    int          acc;
  } item_t;

  // Stand-in multiplier: 18x12 splits the true product across r0/r1; other modes give hashed partials.
  function automatic logic [67:0] fake_mul(input logic [35:0] a, input logic [35:0] b,
                                           input logic as_, input logic bs, input logic [2:0] m);
    logic [63:0]        h;
    logic signed [18:0] ea;
    logic signed [12:0] eb;
    logic signed [31:0] p;
    logic [29:0]        r0, r1, k;
    logic [7:0]         c;
    h = ({28'd0, a} * 64'h9E3779B97F4A7C15) ^ ({28'd0, b} * 64'hC2B2AE3D27D4EB4F) ^ {59'd0, as_, bs, m};
    if (m == 3'b000) begin
      ea = {as_ & a[17], a[17:0]};
      eb = {bs & b[11], b[11:0]};
      p  = ea * eb;
      k  = h[29:0];
      r0 = p[29:0] - k;
      r1 = k;
      c  = h[37:30];
    end else begin
      r0 = h[29:0];
      r1 = h[59:30];
      c  = {h[63:60], h[3:0]} ^ 8'h5A;
    end
    return {c, r1, r0};
  endfunction

  always_comb {mul_result_SIDM_carry, mul_result_1, mul_result_0} =
    fake_mul(mul_a, mul_b, mul_a_sign, mul_b_sign, mul_mode);

  function automatic logic [2:0] exp_mm(input logic [1:0] mode);
    return (mode == 2'b11) ? 3'b000 : {1'b0, mode};
  endfunction

  // Expected {err, data} for a transaction, from the lane-sum rules.
  function automatic logic [32:0] ref_out(input item_t it);
    logic [67:0] mr;
    logic [29:0] r0, r1, s30;
    logic [7:0]  c;
    logic [2:0]  mm;
    logic [31:0] d;
    logic [63:0] t;
    mm = exp_mm(it.mode);
    mr = fake_mul(it.a, it.b, it.as_, it.bs, mm);
    r0 = mr[29:0];
    r1 = mr[59:30];
    c  = mr[67:60];
    d  = 32'd0;
`ifdef MULT_SCHED_MODE_CHECK_EN
    if (it.mode == 2'b11) return {1'b1, 32'd0};
`endif
    case (mm)
      3'b000: begin
        s30 = r0 + r1;
        d   = {{2{s30[29]}}, s30};
      end
      3'b001: begin
        t = ({62'd0, c[3:2]} << 18) + r0[17:0] + r1[17:0];
        d[13:0] = t[19:6];
        t = ({62'd0, c[7:6]} << 12) + r0[29:18] + r1[29:18];
        d[27:14] = t[13:0];
      end
      3'b010: begin
        t = ({62'd0, c[1:0]} << 12) + r0[11:0] + r1[11:0];
        d[7:0] = t[13:6];
        for (int i = 1; i < 4; i++) begin
          t = ({62'd0, c[2*i +: 2]} << 6) + r0[6+6*i +: 6] + r1[6+6*i +: 6];
          d[8*i +: 8] = t[7:0];
        end
      end
      default: d = 32'd0;
    endcase
    return {1'b0, d};
  endfunction

  int    n_checks = 0;
  int    n_errs = 0;
  int    cyc = 0;
  item_t q[$];
  item_t preq[2];
  bit    pend[2];
  bit    last_m = 1'b1;
  bit    after_rst = 1'b1;
  bit    dir_pend = 1'b0;
  item_t dir_item;
  logic [31:0] last_data = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic item_t rand_item();
    item_t       it;
    logic [63:0] r;
    r = {$urandom(), $urandom()}; it.a = r[35:0];
    r = {$urandom(), $urandom()}; it.b = r[35:0];
    r = {32'd0, $urandom()};
    it.as_ = r[0]; it.bs = r[1]; it.mode = r[3:2]; it.tag = r[7:4];
    it.src = 1'b0; it.acc = 0;
    return it;
  endfunction

  // One clock: check state after the last edge, drive the next inputs, check readies, advance the model.
  task automatic step(input int pv, input int pr, input bit rst);
    logic        exp_ov, cap, e0, e1;
    logic [32:0] eo;
    item_t       s1i;
    bit          has_s1;
    @(negedge clk);
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 1);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov && out_valid) begin
      eo = ref_out(q[0]);
      chk("out_data", out_data, eo[31:0]);
      chk("out_err", out_err, eo[32]);
      chk("out_src_tag_mode", {out_src, out_tag, out_mode}, {q[0].src, q[0].tag, q[0].mode});
    end
    has_s1 = 1'b0;
    if (q.size() == 2) begin s1i = q[1]; has_s1 = 1'b1; end
    else if (q.size() == 1 && cyc == q[0].acc) begin s1i = q[0]; has_s1 = 1'b1; end
    if (has_s1) begin
      chk("mul_a", mul_a, s1i.a);
      chk("mul_b", mul_b, s1i.b);
      chk("mul_ctl", {mul_a_sign, mul_b_sign, mul_mode}, {s1i.as_, s1i.bs, exp_mm(s1i.mode)});
    end
    if (after_rst) begin
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_mul", {mul_a, mul_b, mul_mode}, 75'd0);
      chk("rst_out_misc", {out_src, out_tag, out_mode, out_err}, 8'd0);
    end

    reset = rst;
    out_ready = ($urandom_range(0, 99) < pr);
    if (dir_pend && !pend[0]) begin preq[0] = dir_item; pend[0] = 1'b1; dir_pend = 1'b0; end
    for (int n = 0; n < 2; n++)
      if (!pend[n] && $urandom_range(0, 99) < pv) begin preq[n] = rand_item(); pend[n] = 1'b1; end
    req0_valid = pend[0]; req0_a = preq[0].a; req0_b = preq[0].b; req0_a_sign = preq[0].as_;
    req0_b_sign = preq[0].bs; req0_mode = preq[0].mode; req0_tag = preq[0].tag;
    req1_valid = pend[1]; req1_a = preq[1].a; req1_b = preq[1].b; req1_a_sign = preq[1].as_;
    req1_b_sign = preq[1].bs; req1_mode = preq[1].mode; req1_tag = preq[1].tag;
    #1;
    cap = (q.size() < 2) || out_ready;
    e0 = !rst && cap && pend[0] && (!pend[1] || last_m);
    e1 = !rst && cap && pend[1] && (!pend[0] || !last_m);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);

    cyc++;
    if (rst) begin
      q.delete();
      last_m = 1'b1;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (exp_ov && out_ready) begin
        eo = ref_out(q[0]);
        last_data = eo[31:0];
        void'(q.pop_front());
      end
      if (e0) begin preq[0].src = 1'b0; preq[0].acc = cyc; q.push_back(preq[0]); pend[0] = 1'b0; last_m = 1'b0; end
      if (e1) begin preq[1].src = 1'b1; preq[1].acc = cyc; q.push_back(preq[1]); pend[1] = 1'b0; last_m = 1'b1; end
    end
  endtask

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    preq[0] = rand_item(); preq[1] = rand_item();
    repeat (2) step(0, 100, 1'b1);

    dir_item = '{a: 36'hFFFFFFFFF, b: 36'hFFFFFF002, as_: 1'b1, bs: 1'b1, mode: 2'b00,
                 tag: 4'h3, src: 1'b0, acc: 0};
    dir_pend = 1'b1;
    repeat (4) step(0, 100, 1'b0);
    chk("dir_18x12_data", last_data, 32'hFFFFFFFE);

    dir_item = '{a: 36'hFFFFFFFFF, b: 36'hFFFFFFFFF, as_: 1'b0, bs: 1'b0, mode: 2'b01,
                 tag: 4'hA, src: 1'b0, acc: 0};
    dir_pend = 1'b1;
    repeat (4) step(0, 100, 1'b0);

    repeat (10) step(100, 100, 1'b0);
    repeat (5)  step(100, 0, 1'b0);
    repeat (6)  step(100, 100, 1'b0);
    repeat (3)  step(100, 0, 1'b0);
    step(100, 0, 1'b1);
    repeat (6)  step(100, 100, 1'b0);

    for (int i = 0; i < 3000; i++)
      step(60, 70, ($urandom_range(0, 249) == 0));
    repeat (6) step(0, 100, 1'b0);
    chk("drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
